prf_read_arbiter: RTL and testbench
===================================

# prf_read_arbiter

Per-bank read-port arbiter for the banked physical register file. Collects read requests from the 14 operand read requesters, arbitrates each PRF bank's single read port round-robin, and drives the per-bank read address. It holds unserved requests until they are granted, and returns a per-requester ack aligned with the bank read data one cycle later.

## Interface
- RR_COUNT, 14, number of read requesters
- PRF_BANK_COUNT, 4, banks, one read port each (from core_types_pkg)
- LOG_PRF_BANK_COUNT, 2, log2 of bank count (from core_types_pkg)
- LOG_PR_COUNT, 7, physical register index width (from core_types_pkg)
- CLK  in  1  clock; one clock domain
- nRST  in  1  reset, asynchronous, active-low
- raw_req_valid_by_rr  in  RR_COUNT  new read request this cycle
- raw_req_PR_by_rr  in  RR_COUNT x LOG_PR_COUNT  requested PR
- kill_by_rr  in  RR_COUNT  cancel this requester's pending and same-cycle request
- bank_read_valid_by_bank  out  PRF_BANK_COUNT  bank read port enable this cycle
- bank_read_upper_PR_by_bank  out  PRF_BANK_COUNT x (LOG_PR_COUNT-LOG_PRF_BANK_COUNT)  row address within bank
- reg_read_valid_by_rr  out  RR_COUNT  ack: data for this requester is on its bank's read data output this cycle
- pending_by_rr  out  RR_COUNT  requester has an unserved request (stall indication)

## Operation
- Bank select: bank = PR[LOG_PRF_BANK_COUNT-1:0]; row = PR[LOG_PR_COUNT-1:LOG_PRF_BANK_COUNT].
- Per-requester state: pending bit + stored PR.
- Candidate set each cycle: pending requests plus same-cycle raw requests, minus killed requesters. Raw requests are eligible for a grant in their arrival cycle.
- A raw request from a requester whose pending bit is set is a protocol violation. The stored request is kept and the raw one is dropped; the bench flags this.
- Per bank: grant the first candidate at index >= ptr[bank], wrapping modulo RR_COUNT. The grant drives bank_read_valid and bank_read_upper_PR combinationally.
- After a grant to requester k on bank b: ptr[b] <= (k+1) mod RR_COUNT. The pointer does not change when the bank has no grant.
- Ungranted candidates set or keep pending. A granted requester clears pending.
- Kill clears pending next edge, suppresses any grant to that requester this cycle, and suppresses its ack.
- Starvation bound: a pending request is granted within RR_COUNT-1 cycles of becoming pending.
- Requests to different banks are granted in parallel; at most one grant per bank per cycle.

## Timing
- Cycle T: request (raw or pending) wins → bank_read_valid/upper_PR asserted in T.
- PRF returns bank data in T+1 → reg_read_valid_by_rr[k] is registered, asserted in T+1 only.
- Reset values: pending=0, stored PRs=0, all ptr=0, reg_read_valid_by_rr=0.
- While nRST is low, bank_read_valid_by_bank=0 regardless of raw inputs.
- Reset mid-operation: all pending requests are lost, and no ack follows a grant issued in the reset cycle.
- Kill in T+1 of a request granted in T: the ack in T+1 is still asserted. The requester discards it.
- Simultaneous raw request and kill for the same requester: the request is fully ignored.
- Pointer wrap: a grant to requester 13 sets ptr to 0.

## Structure
- core_types_pkg holds PRF_BANK_COUNT, LOG_PRF_BANK_COUNT, LOG_PR_COUNT, and the new constant PRF_RR_COUNT=14.
- Sub-module rr_pointer_arbiter (N-wide request mask + pointer → one-hot grant + valid), instantiated once per bank. Also reusable for writeback bus arbitration.

## Test plan
- Single request: rr 3 raw PR 0x25, idle otherwise → T: bank 1 valid, upper 0x09; T+1: reg_read_valid_by_rr = bit 3 only; pending stays 0.
- Same-bank conflict: rr 0, 5, 9 all request bank 2 in the same cycle, ptr=0 → grants rr 0, then 5, then 9 on consecutive cycles. pending_by_rr shows {5,9}, then {9}, then {}. ptr[2] ends at 10.
- Parallel banks: rr 0..3 request PRs 0x00, 0x01, 0x02, 0x03 → all four banks granted in the same cycle; four acks in the next cycle.
- Wrap and fairness: rr 13 and rr 1 continuously request bank 0, ptr=13 → alternating grants 13, 1, 13, 1. Neither waits more than 1 cycle.
- Kill: rr 4 pending on busy bank 3, kill_by_rr[4] asserted → no grant and no ack for rr 4; pending_by_rr[4]=0 next cycle.
- Reset: three pending requests, nRST pulsed low mid-cycle → pending, acks and bank valids are 0 immediately. After release, ptr=0 and there are no stale grants.

Source files
------------

// File: rtl/prf_read_arbiter_pkg.sv
// Shared constants, types and helpers for the PRF read-port arbiter.
package prf_read_arbiter_pkg;

    localparam int PRF_BANK_COUNT     = 4;
    localparam int LOG_PRF_BANK_COUNT = 2;
    localparam int LOG_PR_COUNT       = 7;
    localparam int PRF_RR_COUNT       = 14;

    localparam int RR_COUNT     = PRF_RR_COUNT;
    localparam int LOG_RR_COUNT = 4;
    localparam int ROW_W        = LOG_PR_COUNT - LOG_PRF_BANK_COUNT;

    typedef logic [LOG_PR_COUNT-1:0]       pr_t;
    typedef logic [ROW_W-1:0]              row_t;
    typedef logic [LOG_PRF_BANK_COUNT-1:0] bank_t;
    typedef logic [LOG_RR_COUNT-1:0]       rr_idx_t;

    // Low PR bits select the bank.
    function automatic bank_t bank_of(input pr_t pr);
        return pr[LOG_PRF_BANK_COUNT-1:0];
    endfunction

    // High PR bits are the row address inside the bank.
    function automatic row_t row_of(input pr_t pr);
        return pr[LOG_PR_COUNT-1:LOG_PRF_BANK_COUNT];
    endfunction

    // Round-robin successor of a granted requester, wrapping at RR_COUNT.
    function automatic rr_idx_t next_ptr(input rr_idx_t k);
        return (k == rr_idx_t'(RR_COUNT - 1)) ? '0 : k + rr_idx_t'(1);
    endfunction

endpackage

// File: rtl/prf_read_arbiter_if.sv
// Requester-side bus of the PRF read arbiter.
//
// Handshake: a requester raises raw_req_valid_by_rr[k] with raw_req_PR_by_rr[k]
// for exactly one cycle per new request and must not issue another while
// pending_by_rr[k] is high. There is no ready: the arbiter always accepts and
// holds the request, and reg_read_valid_by_rr[k] pulses for one cycle when the
// bank read data for that request is available. kill_by_rr[k] drops both the
// held request and a same-cycle raw request.
interface prf_read_arbiter_if;
    import prf_read_arbiter_pkg::*;

    logic [RR_COUNT-1:0]             raw_req_valid_by_rr;
    pr_t  [RR_COUNT-1:0]             raw_req_PR_by_rr;
    logic [RR_COUNT-1:0]             kill_by_rr;
    logic [PRF_BANK_COUNT-1:0]       bank_read_valid_by_bank;
    row_t [PRF_BANK_COUNT-1:0]       bank_read_upper_PR_by_bank;
    logic [RR_COUNT-1:0]             reg_read_valid_by_rr;
    logic [RR_COUNT-1:0]             pending_by_rr;
    rr_idx_t [PRF_BANK_COUNT-1:0]    dbg_ptr_by_bank;

    modport master (
        output raw_req_valid_by_rr, raw_req_PR_by_rr, kill_by_rr,
        input  bank_read_valid_by_bank, bank_read_upper_PR_by_bank,
        input  reg_read_valid_by_rr, pending_by_rr, dbg_ptr_by_bank
    );

    modport slave (
        input  raw_req_valid_by_rr, raw_req_PR_by_rr, kill_by_rr,
        output bank_read_valid_by_bank, bank_read_upper_PR_by_bank,
        output reg_read_valid_by_rr, pending_by_rr, dbg_ptr_by_bank
    );

endinterface

// File: rtl/prf_read_arbiter_rr_pointer_arbiter.sv
// Generic pointer-based round-robin arbiter: grants the first requester at or
// after ptr, wrapping modulo N. Purely combinational; the caller owns the pointer.
module rr_pointer_arbiter #(
    parameter int N     = 14,
    parameter int IDX_W = 4
) (
    input  logic [N-1:0]     req_mask,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant_onehot,
    output logic             grant_valid,
    output logic [IDX_W-1:0] grant_idx
);

    int               pos;
    logic [IDX_W-1:0] pos_idx;

    // Scan from ptr upward with wrap; the first set request wins.
    always_comb begin
        grant_onehot = '0;
        grant_valid  = 1'b0;
        grant_idx    = '0;
        pos          = 0;
        pos_idx      = '0;
        for (int i = 0; i < N; i++) begin
            pos = int'(ptr) + i;
            if (pos >= N) begin
                pos = pos - N;
            end
            pos_idx = IDX_W'(pos);
            if (!grant_valid && req_mask[pos_idx]) begin
                grant_valid           = 1'b1;
                grant_onehot[pos_idx] = 1'b1;
                grant_idx             = pos_idx;
            end
        end
    end

endmodule

// File: rtl/prf_read_arbiter.sv
// Per-bank read-port arbiter for the banked PRF. Holds unserved requests,
// arbitrates each bank's single read port round-robin, and acks each requester
// in the cycle its bank data comes back.
module prf_read_arbiter
    import prf_read_arbiter_pkg::*;
(
    input  logic                CLK,
    input  logic                nRST,
    prf_read_arbiter_if.slave   bus
);

    logic [RR_COUNT-1:0] pending_q, pending_d;
    logic [RR_COUNT-1:0] ack_q, ack_d;
    pr_t  [RR_COUNT-1:0] pr_q, pr_d;
    rr_idx_t [PRF_BANK_COUNT-1:0] ptr_q, ptr_d;

    logic [RR_COUNT-1:0]                     cand;
    logic [RR_COUNT-1:0]                     granted;
    pr_t  [RR_COUNT-1:0]                     pr_eff;
    logic [PRF_BANK_COUNT-1:0][RR_COUNT-1:0] req_by_bank;
    logic [PRF_BANK_COUNT-1:0][RR_COUNT-1:0] grant_by_bank;
    logic [PRF_BANK_COUNT-1:0]               grant_valid;
    rr_idx_t [PRF_BANK_COUNT-1:0]            grant_idx;
    row_t [PRF_BANK_COUNT-1:0]               upper_by_bank;

    // Build the candidate set; a held request always wins over a raw one, so a
    // raw request arriving while pending is ignored.
    always_comb begin
        cand        = '0;
        pr_eff      = '0;
        req_by_bank = '0;
        for (int k = 0; k < RR_COUNT; k++) begin
            pr_eff[k] = pending_q[k] ? pr_q[k] : bus.raw_req_PR_by_rr[k];
            cand[k]   = (pending_q[k] | bus.raw_req_valid_by_rr[k]) & ~bus.kill_by_rr[k];
            for (int b = 0; b < PRF_BANK_COUNT; b++) begin
                req_by_bank[b][k] = cand[k] && (bank_of(pr_eff[k]) == bank_t'(b));
            end
        end
    end

    for (genvar gb = 0; gb < PRF_BANK_COUNT; gb++) begin : g_bank
        rr_pointer_arbiter #(
            .N     (RR_COUNT),
            .IDX_W (LOG_RR_COUNT)
        ) u_arb (
            .req_mask     (req_by_bank[gb]),
            .ptr          (ptr_q[gb]),
            .grant_onehot (grant_by_bank[gb]),
            .grant_valid  (grant_valid[gb]),
            .grant_idx    (grant_idx[gb])
        );
    end

    // Merge bank grants, drive row addresses and compute next state.
    always_comb begin
        granted       = '0;
        upper_by_bank = '0;
        ptr_d         = ptr_q;
        for (int b = 0; b < PRF_BANK_COUNT; b++) begin
            granted = granted | grant_by_bank[b];
            for (int k = 0; k < RR_COUNT; k++) begin
                if (grant_by_bank[b][k]) begin
                    upper_by_bank[b] = upper_by_bank[b] | row_of(pr_eff[k]);
                end
            end
            if (grant_valid[b]) begin
                ptr_d[b] = next_ptr(grant_idx[b]);
            end
        end
        pending_d = cand & ~granted;
        ack_d     = granted;
        pr_d      = pr_q;
        for (int k = 0; k < RR_COUNT; k++) begin
            if (!pending_q[k] && bus.raw_req_valid_by_rr[k]) begin
                pr_d[k] = bus.raw_req_PR_by_rr[k];
            end
        end
    end

    // Request holding, pointers and the data-aligned ack.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            pending_q <= '0;
            pr_q      <= '0;
            ptr_q     <= '0;
            ack_q     <= '0;
        end else begin
            pending_q <= pending_d;
            pr_q      <= pr_d;
            ptr_q     <= ptr_d;
            ack_q     <= ack_d;
        end
    end

    // Bank enables are forced off while reset is asserted.
    assign bus.bank_read_valid_by_bank    = grant_valid & {PRF_BANK_COUNT{nRST}};
    assign bus.bank_read_upper_PR_by_bank = upper_by_bank;
    assign bus.reg_read_valid_by_rr       = ack_q;
    assign bus.pending_by_rr              = pending_q;
    assign bus.dbg_ptr_by_bank            = ptr_q;

endmodule

// File: tb/tb_prf_read_arbiter.sv
// Directed bench for prf_read_arbiter: a per-cycle vector table plus a
// hand-written reset sequence.
module tb_prf_read_arbiter;
    import prf_read_arbiter_pkg::*;

    // ---------------- clock / reset ----------------
    logic CLK;
    logic nRST;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    prf_read_arbiter_if bus ();

    prf_read_arbiter dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    // ---------------- vector table ----------------
    typedef struct {
        logic [13:0]      rv;
        logic [13:0][6:0] pr;
        logic [13:0]      kill;
        logic [3:0]       bv;
        logic [3:0][4:0]  up;
        logic [13:0]      ack;
        logic [13:0]      pend;
        logic [3:0][3:0]  ptr;
    } vec_t;

    localparam int NVEC = 26;
    vec_t vec[NVEC];

    int n_total  = 0;
    int n_passed = 0;
    int viol_cnt = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end else begin
            n_passed++;
        end
    endtask

    task automatic rq(input int n, input int rr, input logic [6:0] pr);
        vec[n].rv[rr] = 1'b1;
        vec[n].pr[rr] = pr;
    endtask

    task automatic ex(input int n, input logic [3:0] bv, input logic [19:0] up,
                      input logic [13:0] ack, input logic [13:0] pend, input logic [15:0] ptr);
        vec[n].bv   = bv;
        vec[n].up   = up;
        vec[n].ack  = ack;
        vec[n].pend = pend;
        vec[n].ptr  = ptr;
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_idle();
        bus.raw_req_valid_by_rr = '0;
        bus.raw_req_PR_by_rr    = '0;
        bus.kill_by_rr          = '0;
    endtask

    task automatic check_outputs(input string tag, input logic [3:0] bv, input logic [13:0] ack,
                                 input logic [13:0] pend);
        chk({tag, "_bank_valid"}, 64'(bus.bank_read_valid_by_bank), 64'(bv));
        chk({tag, "_ack"}, 64'(bus.reg_read_valid_by_rr), 64'(ack));
        chk({tag, "_pending"}, 64'(bus.pending_by_rr), 64'(pend));
    endtask

    // Protocol monitor: raw request from a requester that already has one held.
    always @(negedge CLK) begin
        if (nRST && |(bus.raw_req_valid_by_rr & bus.pending_by_rr & ~bus.kill_by_rr)) begin
            viol_cnt++;
        end
    end

    initial begin
        for (int i = 0; i < NVEC; i++) begin
            vec[i].rv   = '0;
            vec[i].pr   = '0;
            vec[i].kill = '0;
        end
        // single request: rr3 PR 0x25 -> bank1 row 9
        rq(0, 3, 7'h25);
        ex(0, 4'b0010, {5'd0, 5'd0, 5'd9, 5'd0}, 14'h0000, 14'h0000, {4'd0, 4'd0, 4'd0, 4'd0});
        ex(1, 4'b0000, 20'd0, 14'h0008, 14'h0000, {4'd0, 4'd0, 4'd4, 4'd0});
        // same-bank conflict on bank2: rr0, rr5, rr9
        rq(2, 0, 7'h02); rq(2, 5, 7'h06); rq(2, 9, 7'h0A);
        ex(2, 4'b0100, {5'd0, 5'd0, 5'd0, 5'd0}, 14'h0000, 14'h0000, {4'd0, 4'd0, 4'd4, 4'd0});
        ex(3, 4'b0100, {5'd0, 5'd1, 5'd0, 5'd0}, 14'h0001, 14'h0220, {4'd0, 4'd1, 4'd4, 4'd0});
        ex(4, 4'b0100, {5'd0, 5'd2, 5'd0, 5'd0}, 14'h0020, 14'h0200, {4'd0, 4'd6, 4'd4, 4'd0});
        ex(5, 4'b0000, 20'd0, 14'h0200, 14'h0000, {4'd0, 4'd10, 4'd4, 4'd0});
        // parallel banks
        rq(6, 0, 7'h04); rq(6, 1, 7'h09); rq(6, 2, 7'h0E); rq(6, 3, 7'h13);
        ex(6, 4'b1111, {5'd4, 5'd3, 5'd2, 5'd1}, 14'h0000, 14'h0000, {4'd0, 4'd10, 4'd4, 4'd0});
        ex(7, 4'b0000, 20'd0, 14'h000F, 14'h0000, {4'd4, 4'd3, 4'd2, 4'd1});
        // steer ptr[0] to 13, then rr13 / rr1 alternate on bank0
        rq(8, 12, 7'h00);
        ex(8, 4'b0001, 20'd0, 14'h0000, 14'h0000, {4'd4, 4'd3, 4'd2, 4'd1});
        rq(9, 13, 7'h04); rq(9, 1, 7'h08);
        ex(9, 4'b0001, {5'd0, 5'd0, 5'd0, 5'd1}, 14'h1000, 14'h0000, {4'd4, 4'd3, 4'd2, 4'd13});
        rq(10, 13, 7'h04);
        ex(10, 4'b0001, {5'd0, 5'd0, 5'd0, 5'd2}, 14'h2000, 14'h0002, {4'd4, 4'd3, 4'd2, 4'd0});
        rq(11, 1, 7'h08);
        ex(11, 4'b0001, {5'd0, 5'd0, 5'd0, 5'd1}, 14'h0002, 14'h2000, {4'd4, 4'd3, 4'd2, 4'd2});
        rq(12, 13, 7'h04);
        ex(12, 4'b0001, {5'd0, 5'd0, 5'd0, 5'd2}, 14'h2000, 14'h0002, {4'd4, 4'd3, 4'd2, 4'd0});
        ex(13, 4'b0001, {5'd0, 5'd0, 5'd0, 5'd1}, 14'h0002, 14'h2000, {4'd4, 4'd3, 4'd2, 4'd2});
        ex(14, 4'b0000, 20'd0, 14'h2000, 14'h0000, {4'd4, 4'd3, 4'd2, 4'd0});
        // kill of a pending request on busy bank3
        rq(15, 5, 7'h0B);
        ex(15, 4'b1000, {5'd2, 5'd0, 5'd0, 5'd0}, 14'h0000, 14'h0000, {4'd4, 4'd3, 4'd2, 4'd0});
        rq(16, 4, 7'h07); rq(16, 6, 7'h0F);
        ex(16, 4'b1000, {5'd3, 5'd0, 5'd0, 5'd0}, 14'h0020, 14'h0000, {4'd6, 4'd3, 4'd2, 4'd0});
        vec[17].kill[4] = 1'b1;
        ex(17, 4'b0000, 20'd0, 14'h0040, 14'h0010, {4'd7, 4'd3, 4'd2, 4'd0});
        ex(18, 4'b0000, 20'd0, 14'h0000, 14'h0000, {4'd7, 4'd3, 4'd2, 4'd0});
        // simultaneous raw request and kill
        rq(19, 2, 7'h01); vec[19].kill[2] = 1'b1;
        ex(19, 4'b0000, 20'd0, 14'h0000, 14'h0000, {4'd7, 4'd3, 4'd2, 4'd0});
        ex(20, 4'b0000, 20'd0, 14'h0000, 14'h0000, {4'd7, 4'd3, 4'd2, 4'd0});
        // raw request while pending: held PR 0x03 is used, 0x1F dropped
        rq(21, 7, 7'h0B); rq(21, 8, 7'h03);
        ex(21, 4'b1000, {5'd2, 5'd0, 5'd0, 5'd0}, 14'h0000, 14'h0000, {4'd7, 4'd3, 4'd2, 4'd0});
        rq(22, 8, 7'h1F);
        ex(22, 4'b1000, {5'd0, 5'd0, 5'd0, 5'd0}, 14'h0080, 14'h0100, {4'd8, 4'd3, 4'd2, 4'd0});
        ex(23, 4'b0000, 20'd0, 14'h0100, 14'h0000, {4'd9, 4'd3, 4'd2, 4'd0});
        // kill in the ack cycle does not suppress the ack
        rq(24, 10, 7'h05);
        ex(24, 4'b0010, {5'd0, 5'd0, 5'd1, 5'd0}, 14'h0000, 14'h0000, {4'd9, 4'd3, 4'd2, 4'd0});
        vec[25].kill[10] = 1'b1;
        ex(25, 4'b0000, 20'd0, 14'h0400, 14'h0000, {4'd9, 4'd3, 4'd11, 4'd0});

        // ---------------- reset state ----------------
        nRST = 1'b0;
        drive_idle();
        bus.raw_req_valid_by_rr[0] = 1'b1;
        #3;
        check_outputs("reset", 4'b0000, 14'h0000, 14'h0000);
        chk("reset_ptr", 64'(bus.dbg_ptr_by_bank), 64'd0);
        @(negedge CLK);
        @(negedge CLK);
        nRST = 1'b1;
        drive_idle();

        // ---------------- table ----------------
        for (int i = 0; i < NVEC; i++) begin
            @(posedge CLK);
            #1;
            bus.raw_req_valid_by_rr = vec[i].rv;
            bus.raw_req_PR_by_rr    = vec[i].pr;
            bus.kill_by_rr          = vec[i].kill;
            @(negedge CLK);
            check_outputs($sformatf("v%0d", i), vec[i].bv, vec[i].ack, vec[i].pend);
            chk($sformatf("v%0d_upper", i), 64'(bus.bank_read_upper_PR_by_bank), 64'(vec[i].up));
            chk($sformatf("v%0d_ptr", i), 64'(bus.dbg_ptr_by_bank), 64'(vec[i].ptr));
        end

        // ---------------- reset mid-operation ----------------
        @(posedge CLK);
        #1;
        drive_idle();
        bus.raw_req_valid_by_rr[0] = 1'b1; bus.raw_req_PR_by_rr[0] = 7'h00;
        bus.raw_req_valid_by_rr[1] = 1'b1; bus.raw_req_PR_by_rr[1] = 7'h04;
        bus.raw_req_valid_by_rr[2] = 1'b1; bus.raw_req_PR_by_rr[2] = 7'h08;
        bus.raw_req_valid_by_rr[3] = 1'b1; bus.raw_req_PR_by_rr[3] = 7'h0C;
        @(negedge CLK);
        chk("rst_pre_bv", 64'(bus.bank_read_valid_by_bank), 64'h1);
        @(posedge CLK);
        #1;
        drive_idle();
        bus.raw_req_valid_by_rr[5] = 1'b1; bus.raw_req_PR_by_rr[5] = 7'h14;
        @(negedge CLK);
        chk("rst_pre_pending", 64'(bus.pending_by_rr), 64'h000E);
        chk("rst_pre_ack", 64'(bus.reg_read_valid_by_rr), 64'h0001);
        #1;
        nRST = 1'b0;
        #1;
        check_outputs("rst_low", 4'b0000, 14'h0000, 14'h0000);
        @(posedge CLK);
        #1;
        check_outputs("rst_low_edge", 4'b0000, 14'h0000, 14'h0000);
        @(negedge CLK);
        nRST = 1'b1;
        drive_idle();
        @(posedge CLK);
        #1;
        @(negedge CLK);
        check_outputs("rst_after", 4'b0000, 14'h0000, 14'h0000);
        chk("rst_after_ptr", 64'(bus.dbg_ptr_by_bank), 64'd0);
        @(posedge CLK);
        #1;
        bus.raw_req_valid_by_rr[13] = 1'b1; bus.raw_req_PR_by_rr[13] = 7'h00;
        bus.raw_req_valid_by_rr[5]  = 1'b1; bus.raw_req_PR_by_rr[5]  = 7'h04;
        @(negedge CLK);
        chk("post_rst_bv", 64'(bus.bank_read_valid_by_bank), 64'h1);
        chk("post_rst_upper", 64'(bus.bank_read_upper_PR_by_bank), 64'h1);
        @(posedge CLK);
        #1;
        drive_idle();
        @(negedge CLK);
        chk("post_rst_ack", 64'(bus.reg_read_valid_by_rr), 64'h0020);
        chk("post_rst_pending", 64'(bus.pending_by_rr), 64'h2000);

        // exactly one protocol violation was injected (vector 22)
        chk("protocol_violations", 64'(viol_cnt), 64'd1);

        // ---------------- report ----------------
        $display("%0d/%0d checks passed", n_passed, n_total);
        $finish;
    end

endmodule
